// File: rtl/restart_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : restart_scheduler                                               |
// | Purpose  : Collects system-restart causes on the startup clock (JTAG / CSP |
// |            software resets, post-RUN QPLL / DAQ MMCM lock loss), defers    |
// |            while a BPI flash sequence runs (bounded by a timeout) and      |
// |            issues one bounded RESTART pulse to the power-on reset FSM,     |
// |            followed by a quiet hold-off window.                            |
// | Ports    : STUP_CLK, SYS_RST (async, active-high)                          |
// |            JTAG_REQ, CSP_REQ, QPLL_LOCK, MMCM_LOCK, RUN, BPI_SEQ_IDLE      |
// |              - asynchronous level inputs, synchronized here                |
// |            RESTART   - restart request to the POR FSM                      |
// |            CAUSE     - {MMCM, QPLL, CSP, JTAG} multi-hot, valid w/ RESTART |
// |            WINNER    - highest-priority cause (0=JTAG .. 3=MMCM)           |
// |            DEFER_EXP - restart issued because the BPI wait timed out       |
// |            PENDING   - request captured, waiting for BPI idle              |
// |            DROP_CNT  - saturating count of requests ignored                |
// |            STATE     - FSM state code                                      |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module restart_scheduler #(
  parameter logic [7:0]  LOCK_FILT = 8'd100,
  parameter logic [15:0] DEFER_TMO = 16'hFFFF,
  parameter logic [7:0]  RST_WIDTH = 8'd16,
  parameter logic [15:0] HOLDOFF   = 16'd1000,
  parameter logic        QPLL_EN   = 1'b0
) (
  input  logic       STUP_CLK,
  input  logic       SYS_RST,
  input  logic       JTAG_REQ,
  input  logic       CSP_REQ,
  input  logic       QPLL_LOCK,
  input  logic       MMCM_LOCK,
  input  logic       RUN,
  input  logic       BPI_SEQ_IDLE,
  output logic       RESTART,
  output logic [3:0] CAUSE,
  output logic [1:0] WINNER,
  output logic       DEFER_EXP,
  output logic       PENDING,
  output logic [7:0] DROP_CNT,
  output logic [2:0] STATE
);

  localparam logic [15:0] c_DEFER_LAST = DEFER_TMO - 16'd1;
  localparam logic [15:0] c_WIDTH_LAST = {8'd0, RST_WIDTH} - 16'd1;
  localparam logic [15:0] c_HOLD_LAST  = HOLDOFF - 16'd1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DEFER   = 3'd1,
    S_ASSERT  = 3'd2,
    S_HOLDOFF = 3'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-stage synchronizers. Bit map: 0 JTAG, 1 CSP, 2 QPLL, 3 MMCM, 4 RUN, 5 BPI
  // ---------------------------------------------------------------------------
  logic [5:0] sync1_q;
  logic [5:0] sync2_q;
  logic [1:0] swprev_q;
  logic [3:0] ev_q;

  logic       w_run_s;
  logic       w_bpi_s;
  logic [1:0] w_sw_rise;
  logic [1:0] w_lock_loss;
  logic       w_any_ev;

  assign w_run_s   = sync2_q[4];
  assign w_bpi_s   = sync2_q[5];
  assign w_sw_rise = sync2_q[1:0] & ~swprev_q;
  assign w_any_ev  = |ev_q;

  always_ff @(posedge STUP_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      swprev_q <= '0;
      ev_q     <= '0;
    end else begin
      sync1_q  <= {BPI_SEQ_IDLE, RUN, MMCM_LOCK, QPLL_LOCK, CSP_REQ, JTAG_REQ};
      sync2_q  <= sync1_q;
      swprev_q <= sync2_q[1:0];
      // Capture stage: every source firing in the same cycle lands together.
      ev_q     <= {w_lock_loss[1], w_lock_loss[0] & QPLL_EN, w_sw_rise};
    end
  end

  // ---------------------------------------------------------------------------
  // Lock-loss filters (lane 0 = QPLL, lane 1 = MMCM). The counter saturates at
  // LOCK_FILT; lost_q makes a long outage a single event until lock returns.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_lock
    logic [7:0] cnt_q;
    logic       lost_q;
    logic       w_lock_s;

    assign w_lock_s        = sync2_q[2+gi];
    assign w_lock_loss[gi] = (cnt_q == LOCK_FILT) && !lost_q;

    always_ff @(posedge STUP_CLK or posedge SYS_RST) begin
      if (SYS_RST) begin
        cnt_q  <= '0;
        lost_q <= 1'b0;
      end else begin
        if (w_lock_s || !w_run_s) begin
          cnt_q <= '0;
        end else if (cnt_q != LOCK_FILT) begin
          cnt_q <= cnt_q + 8'd1;
        end
        if (w_lock_s) begin
          lost_q <= 1'b0;
        end else if (w_lock_loss[gi]) begin
          lost_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scheduler FSM. One shared counter times DEFER, ASSERT and HOLDOFF; it is
  // zeroed on every state change.
  // ---------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        restart_q, restart_d;
  logic [3:0]  cause_q, cause_d;
  logic [1:0]  winner_q, winner_d;
  logic        dexp_q, dexp_d;
  logic        pend_q, pend_d;
  logic [7:0]  drop_q, drop_d;

  // Lowest set bit wins: JTAG > CSP > QPLL > MMCM.
  function automatic logic [1:0] prio_enc(input logic [3:0] c);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (c[i]) r = 2'(i);
    end
    return r;
  endfunction

  always_ff @(posedge STUP_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      restart_q <= 1'b0;
      cause_q   <= '0;
      winner_q  <= '0;
      dexp_q    <= 1'b0;
      pend_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      restart_q <= restart_d;
      cause_q   <= cause_d;
      winner_q  <= winner_d;
      dexp_q    <= dexp_d;
      pend_q    <= pend_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    restart_d = restart_q;
    cause_d   = cause_q;
    winner_d  = winner_q;
    dexp_d    = dexp_q;
    pend_d    = pend_q;
    drop_d    = drop_q;

    case (state_q)
      S_IDLE: begin
        if (w_any_ev) begin
          cause_d  = cause_q | ev_q;
          winner_d = prio_enc(cause_d);
          cnt_d    = '0;
          if (w_bpi_s) begin
            state_d   = S_ASSERT;
            restart_d = 1'b1;
          end else begin
            state_d = S_DEFER;
            pend_d  = 1'b1;
          end
        end
      end
      S_DEFER: begin
        // Late events join the pending request; the timer keeps running.
        cause_d  = cause_q | ev_q;
        winner_d = prio_enc(cause_d);
        if (w_bpi_s || (cnt_q == c_DEFER_LAST)) begin
          state_d   = S_ASSERT;
          restart_d = 1'b1;
          pend_d    = 1'b0;
          dexp_d    = !w_bpi_s;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_ASSERT: begin
        // BPI status is deliberately ignored here: the pulse runs to length.
        if (cnt_q == c_WIDTH_LAST) begin
          state_d   = S_HOLDOFF;
          restart_d = 1'b0;
          cause_d   = '0;
          winner_d  = '0;
          dexp_d    = 1'b0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == c_HOLD_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if ((state_q == S_ASSERT || state_q == S_HOLDOFF) && w_any_ev && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  assign RESTART   = restart_q;
  assign CAUSE     = cause_q;
  assign WINNER    = winner_q;
  assign DEFER_EXP = dexp_q;
  assign PENDING   = pend_q;
  assign DROP_CNT  = drop_q;
  assign STATE     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_restart_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_restart_scheduler                                            |
// | Purpose  : Self-checking bench for restart_scheduler. Expected timing and  |
// |            outputs are derived from the block's rules as plain arithmetic  |
// |            (input latency, filter length, pulse width, hold-off length)    |
// |            and a small priority/drop model.                                |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_restart_scheduler;

  localparam int RSTW = 16;    // RESTART width
  localparam int HOLD = 1000;  // hold-off length
  localparam int TMO  = 100;   // defer timeout used for this instance
  localparam int FILT = 100;   // lock filter length
  localparam int LAT  = 4;     // input change to RESTART rise (edges)
  localparam int DLAT = 3;     // BPI idle return to RESTART rise (edges)

  logic       STUP_CLK = 1'b0;
  logic       SYS_RST;
  logic       JTAG_REQ, CSP_REQ, QPLL_LOCK, MMCM_LOCK, RUN, BPI_SEQ_IDLE;
  logic       RESTART;
  logic [3:0] CAUSE;
  logic [1:0] WINNER;
  logic       DEFER_EXP, PENDING;
  logic [7:0] DROP_CNT;
  logic [2:0] STATE;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  restart_scheduler #(
    .DEFER_TMO(16'd100)
  ) dut (
    .STUP_CLK    (STUP_CLK),
    .SYS_RST     (SYS_RST),
    .JTAG_REQ    (JTAG_REQ),
    .CSP_REQ     (CSP_REQ),
    .QPLL_LOCK   (QPLL_LOCK),
    .MMCM_LOCK   (MMCM_LOCK),
    .RUN         (RUN),
    .BPI_SEQ_IDLE(BPI_SEQ_IDLE),
    .RESTART     (RESTART),
    .CAUSE       (CAUSE),
    .WINNER      (WINNER),
    .DEFER_EXP   (DEFER_EXP),
    .PENDING     (PENDING),
    .DROP_CNT    (DROP_CNT),
    .STATE       (STATE)
  );

  always #5 STUP_CLK = ~STUP_CLK;
  always @(posedge STUP_CLK) cyc <= cyc + 1;

  // Pulse monitor: counts RESTART pulses and measures their width.
  int   npulse     = 0;
  int   cur_width  = 0;
  int   last_width = 0;
  logic prev_r     = 1'b0;
  always @(negedge STUP_CLK) begin
    if (RESTART && !prev_r) begin
      npulse    = npulse + 1;
      cur_width = 1;
    end else if (RESTART) begin
      cur_width = cur_width + 1;
    end else if (prev_r) begin
      last_width = cur_width;
    end
    prev_r = RESTART;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive point: 1 time unit after the posedge that brings cyc to t.
  task automatic drive_at(input int t);
    do begin
      @(posedge STUP_CLK);
      #1;
    end while (cyc < t);
  endtask

  // Sample point: just after the negedge where cyc == t.
  task automatic sample_at(input int t);
    do @(negedge STUP_CLK); while (cyc < t);
    #1;
  endtask

  // Reference priority: lowest-numbered active cause wins.
  function automatic logic [1:0] top_cause(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i]) return 2'(i);
    return 2'd0;
  endfunction

  int         t, k, j, h, b, b2;
  int         exp_drop   = 0;
  int         exp_pulses = 0;
  logic [1:0] sel;
  logic       qd;
  logic [3:0] exp_cause;

  initial begin
    SYS_RST = 1'b1; JTAG_REQ = 1'b0; CSP_REQ = 1'b0; QPLL_LOCK = 1'b1;
    MMCM_LOCK = 1'b1; RUN = 1'b0; BPI_SEQ_IDLE = 1'b1;

    // Reset state
    sample_at(2);
    chk("reset_outputs", 32'({RESTART, CAUSE, WINNER, DEFER_EXP, PENDING, DROP_CNT}), 0);
    chk("reset_state", 32'(STATE), 0);
    drive_at(4);
    SYS_RST = 1'b0; RUN = 1'b1;

    // JTAG request, BPI idle
    t = cyc + 5 + int'($urandom_range(0, 15));
    drive_at(t); JTAG_REQ = 1'b1;
    sample_at(t + LAT - 1); chk("jtag_not_early", 32'(RESTART), 0);
    sample_at(t + LAT);
    chk("jtag_rise", 32'(RESTART), 1);
    chk("jtag_cause", 32'(CAUSE), 32'h1);
    chk("jtag_winner", 32'(WINNER), 0);
    chk("jtag_dexp", 32'(DEFER_EXP), 0);
    chk("jtag_state_assert", 32'(STATE), 2);
    exp_pulses++;
    sample_at(t + LAT + RSTW - 1); chk("jtag_still_high", 32'(RESTART), 1);
    sample_at(t + LAT + RSTW);
    chk("jtag_fall", 32'(RESTART), 0);
    chk("holdoff_state", 32'(STATE), 3);
    chk("holdoff_cause_clr", 32'(CAUSE), 0);
    chk("jtag_width", 32'(last_width), RSTW);

    // Three CSP edges during hold-off are dropped
    h = t + LAT + RSTW + 50;
    drive_at(h); JTAG_REQ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_at(h + 10 + 4 * i); CSP_REQ = 1'b1;
      drive_at(h + 12 + 4 * i); CSP_REQ = 1'b0;
    end
    exp_drop += 3;
    sample_at(h + 40); chk("drop_3", 32'(DROP_CNT), exp_drop);
    sample_at(t + LAT + RSTW + HOLD - 1); chk("holdoff_last", 32'(STATE), 3);
    sample_at(t + LAT + RSTW + HOLD);
    chk("back_idle", 32'(STATE), 0);
    chk("one_pulse", 32'(npulse), exp_pulses);

    // Lock filter negatives: 99 low cycles, RUN=0, QPLL disabled
    t = cyc + 5;
    drive_at(t); MMCM_LOCK = 1'b0;
    drive_at(t + FILT - 1); MMCM_LOCK = 1'b1;
    sample_at(t + FILT + 20);
    chk("mmcm99_no_pulse", 32'(npulse), exp_pulses);
    chk("mmcm99_idle", 32'(STATE), 0);
    drive_at(t + 130); RUN = 1'b0;
    drive_at(t + 140); MMCM_LOCK = 1'b0;
    drive_at(t + 340); MMCM_LOCK = 1'b1;
    drive_at(t + 350); RUN = 1'b1;
    sample_at(t + 360);
    chk("run0_no_pulse", 32'(npulse), exp_pulses);
    drive_at(t + 370); QPLL_LOCK = 1'b0;
    drive_at(t + 570); QPLL_LOCK = 1'b1;
    sample_at(t + 580);
    chk("qpll_dis_no_pulse", 32'(npulse), exp_pulses);
    chk("qpll_dis_idle", 32'(STATE), 0);

    // MMCM loss coincident with a random software subset
    for (int it = 0; it < 3; it++) begin
      sel = 2'($urandom_range(0, 3));
      qd  = 1'($urandom_range(0, 1));
      t = cyc + 5;
      drive_at(t); MMCM_LOCK = 1'b0; if (qd) QPLL_LOCK = 1'b0;
      drive_at(t + FILT); JTAG_REQ = sel[0]; CSP_REQ = sel[1];
      exp_cause = {1'b1, 1'b0, sel};
      sample_at(t + FILT + LAT - 1); chk("mix_not_early", 32'(RESTART), 0);
      sample_at(t + FILT + LAT);
      chk("mix_rise", 32'(RESTART), 1);
      chk("mix_cause", 32'(CAUSE), 32'(exp_cause));
      chk("mix_winner", 32'(WINNER), 32'(top_cause(exp_cause)));
      exp_pulses++;
      drive_at(t + FILT + LAT + RSTW + 10);
      MMCM_LOCK = 1'b1; QPLL_LOCK = 1'b1; JTAG_REQ = 1'b0; CSP_REQ = 1'b0;
      sample_at(t + FILT + LAT + RSTW + HOLD);
      chk("mix_idle", 32'(STATE), 0);
      chk("mix_drop_same", 32'(DROP_CNT), exp_drop);
    end

    // Deferred CSP request, BPI returns in time, JTAG joins while pending
    t = cyc + 5;
    drive_at(t); BPI_SEQ_IDLE = 1'b0;
    k = t + 5;
    drive_at(k); CSP_REQ = 1'b1;
    drive_at(k + 5); JTAG_REQ = 1'b1;
    sample_at(k + LAT);
    chk("defer_pending", 32'(PENDING), 1);
    chk("defer_state", 32'(STATE), 1);
    chk("defer_no_restart", 32'(RESTART), 0);
    j = k + int'($urandom_range(10, 80));
    drive_at(j); BPI_SEQ_IDLE = 1'b1;
    sample_at(j + DLAT - 1);
    chk("defer_wait_low", 32'(RESTART), 0);
    chk("defer_wait_pend", 32'(PENDING), 1);
    sample_at(j + DLAT);
    chk("defer_rise", 32'(RESTART), 1);
    chk("defer_pend_clr", 32'(PENDING), 0);
    chk("defer_dexp0", 32'(DEFER_EXP), 0);
    chk("defer_cause_or", 32'(CAUSE), 32'h3);
    chk("defer_winner", 32'(WINNER), 0);
    exp_pulses++;
    drive_at(j + DLAT + RSTW + 10); CSP_REQ = 1'b0; JTAG_REQ = 1'b0;
    sample_at(j + DLAT + RSTW + HOLD); chk("defer_idle", 32'(STATE), 0);

    // Defer timeout with BPI held busy
    t = cyc + 5;
    drive_at(t); BPI_SEQ_IDLE = 1'b0;
    k = t + 5;
    drive_at(k); CSP_REQ = 1'b1;
    sample_at(k + LAT + TMO - 1);
    chk("tmo_not_early", 32'(RESTART), 0);
    chk("tmo_pending", 32'(PENDING), 1);
    sample_at(k + LAT + TMO);
    chk("tmo_rise", 32'(RESTART), 1);
    chk("tmo_dexp", 32'(DEFER_EXP), 1);
    chk("tmo_cause", 32'(CAUSE), 32'h2);
    chk("tmo_winner", 32'(WINNER), 1);
    exp_pulses++;
    sample_at(k + LAT + TMO + RSTW);
    chk("tmo_width", 32'(last_width), RSTW);
    chk("tmo_dexp_clr", 32'(DEFER_EXP), 0);

    // Many drops during hold-off: count, then saturate
    b = k + LAT + TMO + RSTW + 10;
    drive_at(b); CSP_REQ = 1'b0; BPI_SEQ_IDLE = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_at(b + 2 + 2 * i); CSP_REQ = 1'b1;
      drive_at(b + 3 + 2 * i); CSP_REQ = 1'b0;
    end
    exp_drop = (exp_drop + 100 > 255) ? 255 : exp_drop + 100;
    sample_at(b + 2 + 200 + 5); chk("drop_103", 32'(DROP_CNT), exp_drop);
    b2 = b + 210;
    for (int i = 0; i < 200; i++) begin
      drive_at(b2 + 2 * i); CSP_REQ = 1'b1;
      drive_at(b2 + 1 + 2 * i); CSP_REQ = 1'b0;
    end
    exp_drop = (exp_drop + 200 > 255) ? 255 : exp_drop + 200;
    sample_at(b2 + 400 + 5);
    chk("drop_sat", 32'(DROP_CNT), exp_drop);
    chk("drop_no_pulse", 32'(npulse), exp_pulses);
    sample_at(k + LAT + TMO + RSTW + HOLD); chk("sat_idle", 32'(STATE), 0);

    // SYS_RST in the third RESTART cycle clears everything asynchronously
    t = cyc + 5;
    drive_at(t); JTAG_REQ = 1'b1;
    drive_at(t + LAT + 2);
    chk("pre_rst_high", 32'(RESTART), 1);
    SYS_RST = 1'b1; JTAG_REQ = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({RESTART, CAUSE, WINNER, DEFER_EXP, PENDING, DROP_CNT}), 0);
    chk("async_rst_state", 32'(STATE), 0);
    drive_at(t + LAT + 5); SYS_RST = 1'b0;

    // Recovery after reset
    t = cyc + 5;
    drive_at(t); CSP_REQ = 1'b1;
    sample_at(t + LAT - 1); chk("recov_not_early", 32'(RESTART), 0);
    sample_at(t + LAT);
    chk("recov_rise", 32'(RESTART), 1);
    chk("recov_cause", 32'(CAUSE), 32'h2);
    chk("recov_winner", 32'(WINNER), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/restart_scheduler.md
# restart_scheduler

Arbitrates system-restart requests on the startup clock domain and issues a single, well-formed restart request to the power-on reset sequencer. Sources are the JTAG and CSP software resets and post-RUN lock loss of the QPLL and DAQ MMCM. A restart is deferred while a BPI flash sequence is in progress, bounded by a timeout. The block sits beside the power-on reset FSM: its RESTART output feeds that FSM's restart input, and SYS_RST from the reset manager clears it.

## Interface
Parameters:
- LOCK_FILT, 8'd100: consecutive low cycles of a synchronized lock before lock loss is declared.
- DEFER_TMO, 16'hFFFF: maximum cycles spent waiting for BPI idle.
- RST_WIDTH, 8'd16: maximum RESTART high time in cycles.
- HOLDOFF, 16'd1000: quiet cycles after a RESTART that did not produce SYS_RST.
- QPLL_EN, 1'b0: when 0, QPLL lock loss is ignored.

Ports:
- STUP_CLK, in, 1: startup clock. Sole clock.
- SYS_RST, in, 1: asynchronous, active-high reset.
- JTAG_REQ, in, 1: JTAG system reset request, async level.
- CSP_REQ, in, 1: CSP system reset request, async level.
- QPLL_LOCK, in, 1: async.
- MMCM_LOCK, in, 1: DAQ MMCM lock, async.
- RUN, in, 1: run indication from the CLK domain, async.
- BPI_SEQ_IDLE, in, 1: async.
- RESTART, out, 1: restart request to the POR FSM.
- CAUSE, out, 4: {MMCM, QPLL, CSP, JTAG}, multi-hot. Valid while RESTART=1.
- WINNER, out, 2: encoded highest-priority cause (0=JTAG, 1=CSP, 2=QPLL, 3=MMCM).
- DEFER_EXP, out, 1: the restart was issued on defer timeout.
- PENDING, out, 1: a request is captured and not yet issued.
- DROP_CNT, out, 8: saturating count of requests ignored in ASSERT or HOLDOFF.
- STATE, out, 3: FSM state code.

## Operation
- Synchronization: every async input passes through a 2-FF synchronizer on STUP_CLK.
- JTAG and CSP requests are rising-edge detected after synchronization.
- Lock loss is level-filtered. A per-lock counter counts consecutive low cycles, is active only while synced RUN=1, and clears on any high sample or when RUN=0. Lock loss is declared when the counter reaches LOCK_FILT. It is one event per loss; it re-arms only after the lock returns high.
- Priority is fixed: JTAG > CSP > QPLL > MMCM. CAUSE records every source active in the capture cycle. WINNER encodes the highest-priority bit set.
- States:
  - IDLE (0): default. Any event ORs into CAUSE. Go to ASSERT if BPI idle, otherwise DEFER.
  - DEFER (1): PENDING=1. Further events OR into CAUSE; the defer timer is not restarted. Go to ASSERT on BPI idle, or when the timer equals DEFER_TMO-1 (then DEFER_EXP=1).
  - ASSERT (2): RESTART=1 for RST_WIDTH cycles, then go to HOLDOFF. SYS_RST is the normal exit and resets the block mid-pulse.
  - HOLDOFF (3): lasts HOLDOFF cycles. CAUSE, WINNER and DEFER_EXP clear on entry. Then go to IDLE.
- Events arriving in ASSERT or HOLDOFF are dropped and DROP_CNT increments, saturating at 8'hFF.
- Reset (SYS_RST high) is asynchronous and sets: state IDLE, RESTART=0, CAUSE=0, WINNER=0, DEFER_EXP=0, PENDING=0, DROP_CNT=0, all counters and synchronizers 0.
- Because SYS_RST clears CAUSE, the POR FSM must latch CAUSE on the rising edge of RESTART.

## Timing
- All outputs are registered.
- Software request latency: edge at an input FF → 2 sync cycles → capture in cycle 3 → RESTART=1 after the 4th STUP_CLK edge when BPI is idle.
- Lock-loss latency: 2 sync cycles + LOCK_FILT + 1 cycles.
- RESTART is never high for fewer than 1 or more than RST_WIDTH cycles.
- Between two RESTART pulses without SYS_RST there are at least HOLDOFF low cycles.
- BPI_SEQ_IDLE dropping during ASSERT does not affect the pulse.

## Test plan
- JTAG_REQ rising, BPI idle, SYS_RST never asserted → RESTART high 16 cycles starting 4 edges after input; CAUSE=4'b0001, WINNER=0; then 1000-cycle HOLDOFF, back to IDLE.
- JTAG_REQ and MMCM lock loss coincident in the capture cycle → CAUSE=4'b1001, WINNER=0.
- BPI_SEQ_IDLE=0 with CSP_REQ; idle returns after 500 cycles → PENDING=1 during the wait, RESTART 1 cycle after synced idle, DEFER_EXP=0. With BPI held low, DEFER_TMO=16'd100 → RESTART issued after 100 cycles, DEFER_EXP=1.
- RUN=1, MMCM_LOCK low for 99 cycles then high → no event. Low for 100 cycles → CAUSE=4'b1000. RUN=0 with lock low → no event. QPLL loss with QPLL_EN=0 → no event.
- Three CSP edges during HOLDOFF → DROP_CNT=3. 300 edges → DROP_CNT=8'hFF.
- SYS_RST asserted at RESTART cycle 3 → all outputs 0 immediately (asynchronous), STATE=0.
